// File: rtl/airlock_controller.sv
// Airlock door/pump sequencer (Moore FSM) sitting in front of the pressure stage.
// Optional dwell-based automatic door close when AIRLOCK_AUTO_CLOSE_EN is defined.
module airlock_controller #(
   parameter logic [7:0] PRES_HIGH         = 8'd40,
   parameter logic [7:0] PRES_LOW          = 8'd0,
`ifdef AIRLOCK_AUTO_CLOSE_EN
   parameter logic [7:0] AUTO_CLOSE_CYCLES = 8'd16,
`endif
   parameter logic [7:0] TIMEOUT_CYCLES    = 8'd60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] pressure,
   input  logic       requestInner,
   input  logic       requestOuter,
   input  logic       closeDoor,
   output logic       startPressurization,
   output logic       startDepressurization,
   output logic       innerDoorOpen,
   output logic       outerDoorOpen,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      PRES_CLOSED = 3'd0,
      INNER_OPEN  = 3'd1,
      DEPRESS     = 3'd2,
      VAC_CLOSED  = 3'd3,
      OUTER_OPEN  = 3'd4,
      PRESS       = 3'd5,
      FAULT_ST    = 3'd6
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] tmo_r;
   logic       tmo_hit_s;
   logic       auto_close_s;
   logic       press_r;
   logic       depress_r;
   logic       inner_r;
   logic       outer_r;
   logic       fault_r;

   assign tmo_hit_s = (tmo_r == (TIMEOUT_CYCLES - 8'd1));

`ifdef AIRLOCK_AUTO_CLOSE_EN
   logic [7:0] dwell_r;

   // Dwell counter: runs only while a door is open, zero otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dwell_r <= 8'd0;
      end else if ((state_r == INNER_OPEN) || (state_r == OUTER_OPEN)) begin
         if (dwell_r != 8'hFF) begin
            dwell_r <= dwell_r + 8'd1;
         end else begin
            dwell_r <= dwell_r;
         end
      end else begin
         dwell_r <= 8'd0;
      end
   end

   assign auto_close_s = (dwell_r == (AUTO_CLOSE_CYCLES - 8'd1));
`else
   assign auto_close_s = 1'b0;
`endif

   // Pump timeout counter: zero outside pump states, so it is clear on entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_r <= 8'd0;
      end else if ((state_r == DEPRESS) || (state_r == PRESS)) begin
         if (tmo_r != 8'hFF) begin
            tmo_r <= tmo_r + 8'd1;
         end else begin
            tmo_r <= tmo_r;
         end
      end else begin
         tmo_r <= 8'd0;
      end
   end

   // Next-state logic; threshold checks take priority over the timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         PRES_CLOSED: begin
            if (requestInner) begin
               if (pressure >= PRES_HIGH) begin
                  state_nxt_s = INNER_OPEN;
               end else begin
                  state_nxt_s = PRESS;
               end
            end else if (requestOuter) begin
               state_nxt_s = DEPRESS;
            end else begin
               state_nxt_s = PRES_CLOSED;
            end
         end
         INNER_OPEN: begin
            if (closeDoor || auto_close_s) begin
               state_nxt_s = PRES_CLOSED;
            end else begin
               state_nxt_s = INNER_OPEN;
            end
         end
         DEPRESS: begin
            if (pressure <= PRES_LOW) begin
               state_nxt_s = OUTER_OPEN;
            end else if (tmo_hit_s) begin
               state_nxt_s = FAULT_ST;
            end else begin
               state_nxt_s = DEPRESS;
            end
         end
         VAC_CLOSED: begin
            if (requestOuter) begin
               state_nxt_s = OUTER_OPEN;
            end else if (requestInner) begin
               state_nxt_s = PRESS;
            end else begin
               state_nxt_s = VAC_CLOSED;
            end
         end
         OUTER_OPEN: begin
            if (closeDoor || auto_close_s) begin
               state_nxt_s = VAC_CLOSED;
            end else begin
               state_nxt_s = OUTER_OPEN;
            end
         end
         PRESS: begin
            if (pressure >= PRES_HIGH) begin
               state_nxt_s = INNER_OPEN;
            end else if (tmo_hit_s) begin
               state_nxt_s = FAULT_ST;
            end else begin
               state_nxt_s = PRESS;
            end
         end
         FAULT_ST: state_nxt_s = FAULT_ST;
         default:  state_nxt_s = FAULT_ST;
      endcase
   end

   // State and output registers; outputs decode the next state so they track state_r.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= PRES_CLOSED;
         press_r   <= 1'b0;
         depress_r <= 1'b0;
         inner_r   <= 1'b0;
         outer_r   <= 1'b0;
         fault_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         press_r   <= (state_nxt_s == PRESS);
         depress_r <= (state_nxt_s == DEPRESS);
         inner_r   <= (state_nxt_s == INNER_OPEN);
         outer_r   <= (state_nxt_s == OUTER_OPEN);
         fault_r   <= (state_nxt_s == FAULT_ST);
      end
   end

   assign state                 = state_r;
   assign startPressurization   = press_r;
   assign startDepressurization = depress_r;
   assign innerDoorOpen         = inner_r;
   assign outerDoorOpen         = outer_r;
   assign fault                 = fault_r;

endmodule

// File: tb/tb_airlock_controller.sv
// Scoreboard bench for airlock_controller: expected states queued with each stimulus
// cycle and compared (state plus decoded outputs) after the edge.
module tb_airlock_controller;

   logic       clock;
   logic       reset;
   logic [7:0] pressure;
   logic       requestInner;
   logic       requestOuter;
   logic       closeDoor;
   logic       startPressurization;
   logic       startDepressurization;
   logic       innerDoorOpen;
   logic       outerDoorOpen;
   logic       fault;
   logic [2:0] state;

   int         err_cnt;
   int         chk_cnt;
   logic [2:0] exp_q[$];

   airlock_controller dut (
      .clock                 (clock),
      .reset                 (reset),
      .pressure              (pressure),
      .requestInner          (requestInner),
      .requestOuter          (requestOuter),
      .closeDoor             (closeDoor),
      .startPressurization   (startPressurization),
      .startDepressurization (startDepressurization),
      .innerDoorOpen         (innerDoorOpen),
      .outerDoorOpen         (outerDoorOpen),
      .fault                 (fault),
      .state                 (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      chk_cnt = chk_cnt + 1;
      if (obs !== exp_v) begin
         err_cnt = err_cnt + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Compare state and every output against the Moore decode of the expected state.
   task automatic chk_all(input string tag, input logic [2:0] es);
      chk({tag, ".state"},   {5'd0, state},                  {5'd0, es});
      chk({tag, ".inner"},   {7'd0, innerDoorOpen},          {7'd0, es == 3'd1});
      chk({tag, ".outer"},   {7'd0, outerDoorOpen},          {7'd0, es == 3'd4});
      chk({tag, ".depress"}, {7'd0, startDepressurization},  {7'd0, es == 3'd2});
      chk({tag, ".press"},   {7'd0, startPressurization},    {7'd0, es == 3'd5});
      chk({tag, ".fault"},   {7'd0, fault},                  {7'd0, es == 3'd6});
   endtask

   task automatic step(input string tag, input logic ri, input logic ro, input logic cd,
                       input logic [7:0] p, input logic [2:0] es);
      logic [2:0] got_exp;
      requestInner = ri;
      requestOuter = ro;
      closeDoor    = cd;
      pressure     = p;
      exp_q.push_back(es);
      @(posedge clock);
      #1;
      got_exp = exp_q.pop_front();
      chk_all(tag, got_exp);
      requestInner = 1'b0;
      requestOuter = 1'b0;
      closeDoor    = 1'b0;
   endtask

   initial begin
      err_cnt      = 0;
      chk_cnt      = 0;
      reset        = 1'b1;
      pressure     = 8'd40;
      requestInner = 1'b0;
      requestOuter = 1'b0;
      closeDoor    = 1'b0;
      #12;
      chk_all("reset", 3'd0);
      reset = 1'b0;

      // Inner door cycle at full pressure
      step("inner_open", 1'b1, 1'b0, 1'b0, 8'd40, 3'd1);
      step("inner_ignore", 1'b0, 1'b1, 1'b0, 8'd40, 3'd1);
      step("inner_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);

      // Depressurize 40 -> 0 at 2 per cycle
      step("dep_enter", 1'b0, 1'b1, 1'b0, 8'd40, 3'd2);
      for (int i = 1; i <= 19; i++) step("dep_pump", 1'b0, 1'b0, 1'b0, 8'(40 - 2 * i), 3'd2);
      step("dep_done", 1'b0, 1'b0, 1'b0, 8'd0, 3'd4);
      step("outer_close", 1'b0, 1'b0, 1'b1, 8'd0, 3'd3);

      // Repressurize 0 -> 40 at 1 per cycle
      step("pr_enter", 1'b1, 1'b0, 1'b0, 8'd0, 3'd5);
      for (int i = 1; i <= 39; i++) step("pr_pump", 1'b0, 1'b0, 1'b0, 8'(i), 3'd5);
      step("pr_done", 1'b0, 1'b0, 1'b0, 8'd40, 3'd1);
      step("pr_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);

      // Back to vacuum, then simultaneous requests: outer wins
      step("dep2_enter", 1'b0, 1'b1, 1'b0, 8'd40, 3'd2);
      step("dep2_done", 1'b0, 1'b0, 1'b0, 8'd0, 3'd4);
      step("outer2_close", 1'b0, 1'b0, 1'b1, 8'd0, 3'd3);
      step("vac_both", 1'b1, 1'b1, 1'b0, 8'd0, 3'd4);
      step("outer3_close", 1'b0, 1'b0, 1'b1, 8'd0, 3'd3);
      step("pr2_enter", 1'b1, 1'b0, 1'b0, 8'd0, 3'd5);
      step("pr2_done", 1'b0, 1'b0, 1'b0, 8'd40, 3'd1);
      step("pr2_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);

      // Simultaneous requests when pressurized: inner wins
      step("pc_both", 1'b1, 1'b1, 1'b0, 8'd40, 3'd1);
      step("pc_both_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);

      // Stuck pressure: FAULT on the 60th edge after entry
      step("to_enter", 1'b0, 1'b1, 1'b0, 8'd30, 3'd2);
      for (int i = 1; i <= 59; i++) step("to_pump", 1'b0, 1'b0, 1'b0, 8'd30, 3'd2);
      step("to_fault", 1'b0, 1'b0, 1'b0, 8'd30, 3'd6);
      step("fault_hold_i", 1'b1, 1'b0, 1'b0, 8'd40, 3'd6);
      step("fault_hold_o", 1'b0, 1'b1, 1'b1, 8'd0, 3'd6);
      reset = 1'b1;
      #1;
      chk_all("fault_reset", 3'd0);
      reset = 1'b0;

      // Low pressure inner request repressurizes; async reset mid-pump
      step("leak_press", 1'b1, 1'b0, 1'b0, 8'd20, 3'd5);
      step("leak_pump", 1'b0, 1'b0, 1'b0, 8'd20, 3'd5);
      #3;
      reset = 1'b1;
      #1;
      chk("async_press", {7'd0, startPressurization}, 8'd0);
      chk("async_state", {5'd0, state}, 8'd0);
      #1;
      reset = 1'b0;
      step("leak2_press", 1'b1, 1'b0, 1'b0, 8'd20, 3'd5);
      step("pres_39", 1'b0, 1'b0, 1'b0, 8'd39, 3'd5);
      step("pres_40", 1'b0, 1'b0, 1'b0, 8'd40, 3'd1);
      step("leak2_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);

      // Threshold reached on the timeout cycle: threshold wins
      step("tw_enter", 1'b0, 1'b1, 1'b0, 8'd30, 3'd2);
      for (int i = 1; i <= 59; i++) step("tw_pump", 1'b0, 1'b0, 1'b0, 8'd30, 3'd2);
      step("tw_open", 1'b0, 1'b0, 1'b0, 8'd0, 3'd4);
      step("tw_close", 1'b0, 1'b0, 1'b1, 8'd0, 3'd3);
      step("tw_pr", 1'b1, 1'b0, 1'b0, 8'd0, 3'd5);
      step("tw_pr_done", 1'b0, 1'b0, 1'b0, 8'd41, 3'd1);
      step("tw_pr_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);

      // Door dwell behaviour
      step("dwell_open", 1'b1, 1'b0, 1'b0, 8'd40, 3'd1);
`ifdef AIRLOCK_AUTO_CLOSE_EN
      for (int i = 1; i <= 15; i++) step("dwell_hold", 1'b0, 1'b0, 1'b0, 8'd40, 3'd1);
      step("dwell_close", 1'b0, 1'b0, 1'b0, 8'd40, 3'd0);
`else
      for (int i = 1; i <= 100; i++) step("dwell_hold", 1'b0, 1'b0, 1'b0, 8'd40, 3'd1);
      step("dwell_close", 1'b0, 1'b0, 1'b1, 8'd40, 3'd0);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
